// File: rtl/bus_pkg.sv
// Shared definitions for the request/response bus: default widths, the
// out-of-range read word, request encoding and responder FSM states.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 16;

  // Word returned for out-of-range reads when error reporting is built in
  localparam logic [15:0] ERR_WORD = 16'hDEAD;

  // req_rw encoding
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } bus_state_e;

endpackage : bus_pkg

// File: rtl/bus_resp_reg.sv
// One-entry response holding register. A load strobe captures a word and
// raises res_valid. The word is held until the downstream takes it with
// res_ready.
module bus_resp_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_valid,
  input  logic                  res_ready
);

  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  valid_d, valid_q;

  // Next state: a load wins; otherwise a taken response clears the entry
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && res_ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign res_data  = data_q;
  assign res_valid = valid_q;

endmodule : bus_resp_reg

// File: rtl/bus_regfile.sv
// Bus responder with DEPTH registers mapped at BASE_ADDR. Writes complete on
// the accepting edge. Reads go IDLE -> FETCH -> RESP and return one response
// each. All registers are exported in parallel on regs_q.
// Optional feature macro BUS_REGFILE_ERR_EN: out-of-range reads return
// ERR_WORD and any out-of-range request sets the sticky err flag.
module bus_regfile
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0]       req_data,
  input  logic                        req_rw,
  input  logic                        req_valid,
  output logic                        req_ready,
  output logic [DATA_WIDTH-1:0]       res_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DEPTH*DATA_WIDTH-1:0] regs_q,
  output logic                        err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so base+depth cannot overflow and alias low addresses
  localparam int OFS_W = ADDR_WIDTH + 1;
  localparam logic [OFS_W-1:0] BASE_EXT  = OFS_W'(BASE_ADDR);
  localparam logic [OFS_W-1:0] DEPTH_EXT = OFS_W'(DEPTH);

`ifdef BUS_REGFILE_ERR_EN
  localparam logic [DATA_WIDTH-1:0] OOR_WORD = DATA_WIDTH'(ERR_WORD);
`else
  localparam logic [DATA_WIDTH-1:0] OOR_WORD = '0;
`endif

  bus_state_e                  state_d, state_q;
  logic [IDX_W-1:0]            idx_d, idx_q;
  logic                        hit_d, hit_q;
  logic [DEPTH*DATA_WIDTH-1:0] regs_d;

  logic [OFS_W-1:0]      offset;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  req_fire;
  logic                  load;
  logic [DATA_WIDTH-1:0] fetch_data;

  // Address decode relative to BASE_ADDR
  always_comb begin
    offset   = {1'b0, req_addr} - BASE_EXT;
    in_range = ({1'b0, req_addr} >= BASE_EXT) && (offset < DEPTH_EXT);
    idx      = offset[IDX_W-1:0];
  end

  assign req_ready = (state_q == IDLE);
  assign req_fire  = req_valid && req_ready;

  // Word presented to the response register during FETCH
  assign fetch_data = hit_q ? regs_q[idx_q*DATA_WIDTH +: DATA_WIDTH] : OOR_WORD;

  // FSM next state, register writes and read-address capture
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    regs_d  = regs_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (req_rw == RW_WRITE) begin
            if (in_range) regs_d[idx*DATA_WIDTH +: DATA_WIDTH] = req_data;
          end else begin
            idx_d   = idx;
            hit_d   = in_range;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        load    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (res_valid && res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, read capture and register array
  // NOTE: the register array is reset because user logic consumes regs_q
  // directly and must never see undefined contents after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      regs_q  <= regs_d;
    end
  end

`ifdef BUS_REGFILE_ERR_EN
  logic err_d, err_q;

  // Sticky flag: set by any accepted out-of-range request, cleared by reset
  always_comb begin
    err_d = err_q | (req_fire && !in_range);
  end

  // Error flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  bus_resp_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (fetch_data),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

endmodule : bus_regfile

// File: tb/tb_bus_regfile.sv
// Directed bench for bus_regfile mapped at 0x10 with 8 x 16-bit registers.
module tb_bus_regfile;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int BASE  = 16'h10;

`ifdef BUS_REGFILE_ERR_EN
  localparam logic [15:0] OOR_EXP = 16'hDEAD;
  localparam logic        ERR_EXP = 1'b1;
`else
  localparam logic [15:0] OOR_EXP = 16'h0000;
  localparam logic        ERR_EXP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [AW-1:0]         req_addr;
  logic [DW-1:0]         req_data;
  logic                  req_rw;
  logic                  req_valid;
  logic                  req_ready;
  logic [DW-1:0]         res_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [DEPTH*DW-1:0]   regs_q;
  logic                  err;

  int total = 0;
  int bad   = 0;

  logic [DEPTH*DW-1:0] exp_regs;

  bus_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rw    (req_rw),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .regs_q    (regs_q),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_addr  = '0;
    req_data  = '0;
    req_rw    = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    exp_regs  = '0;
    step();
    step();
    check("ready_in_reset", 128'(req_ready), 128'(1'b1));
    rst = 1'b0;
    step();
    check("rst_req_ready", 128'(req_ready), 128'(1'b1));
    check("rst_res_valid", 128'(res_valid), 128'(1'b0));
    check("rst_regs", 128'(regs_q), 128'(exp_regs));
    check("rst_err", 128'(err), 128'(1'b0));

    // Back-to-back writes to reg 0 and reg 7
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h10; req_data = 16'h1234;
    step();
    exp_regs[0*DW +: DW] = 16'h1234;
    check("wr0_regs", 128'(regs_q), 128'(exp_regs));
    check("wr0_ready", 128'(req_ready), 128'(1'b1));
    req_addr = 16'h17; req_data = 16'hBEEF;
    step();
    exp_regs[7*DW +: DW] = 16'hBEEF;
    check("wr7_regs", 128'(regs_q), 128'(exp_regs));
    check("wr7_ready", 128'(req_ready), 128'(1'b1));

    // Read 0x17 in the very next cycle: must see the new value
    req_rw = 1'b0; req_addr = 16'h17; res_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("rd7_fetch_valid", 128'(res_valid), 128'(1'b0));
    check("rd7_fetch_ready", 128'(req_ready), 128'(1'b0));
    step();
    check("rd7_valid", 128'(res_valid), 128'(1'b1));
    check("rd7_data", 128'(res_data), 128'(16'hBEEF));
    step();
    check("rd7_done_valid", 128'(res_valid), 128'(1'b0));
    check("rd7_done_ready", 128'(req_ready), 128'(1'b1));

    // Backpressure: read 0x10 with res_ready low for 5 cycles
    res_ready = 1'b0;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h10;
    step();
    req_valid = 1'b0;
    step();
    check("bp_valid", 128'(res_valid), 128'(1'b1));
    check("bp_data", 128'(res_data), 128'(16'h1234));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 128'(res_valid), 128'(1'b1));
      check("bp_hold_data", 128'(res_data), 128'(16'h1234));
      check("bp_hold_ready", 128'(req_ready), 128'(1'b0));
    end
    res_ready = 1'b1;
    step();
    check("bp_done_valid", 128'(res_valid), 128'(1'b0));
    check("bp_done_ready", 128'(req_ready), 128'(1'b1));

    // Out-of-range write just below the window
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0F; req_data = 16'hAAAA;
    step();
    check("oor_wr_regs", 128'(regs_q), 128'(exp_regs));
    check("oor_wr_err", 128'(err), 128'(ERR_EXP));

    // Out-of-range read just above the window (no wrap to reg 0)
    req_rw = 1'b0; req_addr = 16'h18;
    step();
    req_valid = 1'b0;
    step();
    check("oor_rd_valid", 128'(res_valid), 128'(1'b1));
    check("oor_rd_data", 128'(res_data), 128'(OOR_EXP));
    step();
    check("oor_rd_done", 128'(res_valid), 128'(1'b0));
    check("oor_regs", 128'(regs_q), 128'(exp_regs));
    check("oor_err_sticky", 128'(err), 128'(ERR_EXP));

    // Reset while a response is waiting in RESP
    res_ready = 1'b0;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h17;
    step();
    req_valid = 1'b0;
    step();
    check("mid_valid_pre", 128'(res_valid), 128'(1'b1));
    rst = 1'b1;
    #1;
    exp_regs = '0;
    check("mid_valid_drop", 128'(res_valid), 128'(1'b0));
    check("mid_regs", 128'(regs_q), 128'(exp_regs));
    check("mid_err", 128'(err), 128'(1'b0));
    check("mid_ready", 128'(req_ready), 128'(1'b1));
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_valid", 128'(res_valid), 128'(1'b0));
      check("post_rst_ready", 128'(req_ready), 128'(1'b1));
    end
    check("post_rst_regs", 128'(regs_q), 128'(exp_regs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bus_regfile
